// File: rtl/ped_request.sv
// Pedestrian push-button front end: sync + debounce, one latched request held
// until acknowledged, blinking WAIT LED while pending, press lockout after ack.
module ped_request #(
    parameter int DEBOUNCE_TICKS = 160000,
    parameter int BLINK_TICKS    = 4000000,
    parameter int LOCKOUT_TICKS  = 32000000
) (
    input  logic       pin3_clk_16mhz,
    input  logic       rst,
    input  logic       pin9_ped_button,
    input  logic       ped_ack,
    output logic       ped_req,
    output logic       pin10_wait_led,
    output logic [7:0] press_count
);
    localparam int DW = $clog2(DEBOUNCE_TICKS);
    localparam int BW = $clog2(BLINK_TICKS);
    localparam int LW = $clog2(LOCKOUT_TICKS);

    typedef enum logic [1:0] {IDLE, PENDING, LOCKOUT} state_t;

    logic          s1, s2, stable, stable_d;
    logic [DW-1:0] dcnt;
    logic          press;

    state_t        state, next_state;
    logic [BW-1:0] bcnt, bcnt_next;
    logic [LW-1:0] lcnt, lcnt_next;
    logic          req_next, led_next;

    always_ff @(posedge pin3_clk_16mhz) begin
        if (rst) begin
            s1       <= 1'b0;
            s2       <= 1'b0;
            stable   <= 1'b0;
            stable_d <= 1'b0;
            dcnt     <= '0;
        end else begin
            s1       <= pin9_ped_button;
            s2       <= s1;
            stable_d <= stable;
            if (s2 == stable) begin
                dcnt <= '0;
            end else if (dcnt == DW'(DEBOUNCE_TICKS - 1)) begin
                stable <= s2;
                dcnt   <= '0;
            end else begin
                dcnt <= dcnt + 1'b1;
            end
        end
    end

    // Only the rising edge of the debounced level is a press; release is silent.
    assign press = stable & ~stable_d;

    always_ff @(posedge pin3_clk_16mhz) begin
        if (rst) begin
            press_count <= 8'd0;
        end else if (press && press_count != 8'hff) begin
            press_count <= press_count + 8'd1;
        end
    end

    always_ff @(posedge pin3_clk_16mhz) begin
        if (rst) begin
            state          <= IDLE;
            bcnt           <= '0;
            lcnt           <= '0;
            ped_req        <= 1'b0;
            pin10_wait_led <= 1'b0;
        end else begin
            state          <= next_state;
            bcnt           <= bcnt_next;
            lcnt           <= lcnt_next;
            ped_req        <= req_next;
            pin10_wait_led <= led_next;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (press) next_state = PENDING;
            PENDING: if (ped_ack) next_state = LOCKOUT;
            LOCKOUT: if (lcnt == LW'(LOCKOUT_TICKS - 1)) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Outputs are registered from next_state so they line up with the state reg.
    always_comb begin
        req_next  = (next_state == PENDING);
        led_next  = 1'b0;
        bcnt_next = '0;
        lcnt_next = '0;
        if (next_state == PENDING) begin
            if (state != PENDING) begin
                led_next = 1'b1;
            end else if (bcnt == BW'(BLINK_TICKS - 1)) begin
                led_next = ~pin10_wait_led;
            end else begin
                led_next  = pin10_wait_led;
                bcnt_next = bcnt + 1'b1;
            end
        end
        if (state == LOCKOUT && next_state == LOCKOUT) begin
            lcnt_next = lcnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_ped_request.sv
// Bench for ped_request: directed scenario tasks plus a randomized run against
// an edge-indexed behavioural model of the button/request rules.
module tb_ped_request;
    localparam int DT = 4;
    localparam int BT = 3;
    localparam int LT = 5;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       button = 1'b0;
    logic       ack = 1'b0;
    logic       ped_req, led;
    logic [7:0] press_count;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    ped_request #(
        .DEBOUNCE_TICKS(DT),
        .BLINK_TICKS(BT),
        .LOCKOUT_TICKS(LT)
    ) dut (
        .pin3_clk_16mhz(clk),
        .rst(rst),
        .pin9_ped_button(button),
        .ped_ack(ack),
        .ped_req(ped_req),
        .pin10_wait_led(led),
        .press_count(press_count)
    );

    // Reference model, indexed by clock edge number. Disagreement is tracked by
    // the edge at which it began; a press takes effect one edge after the flip.
    int         cyc = 0;
    bit         d1 = 0, d2 = 0, m_st = 0, armed = 0;
    int         dis_start = -1;
    int         mstate = 0;      // 0 idle, 1 pending, 2 lockout
    int         since = 0;
    int         m_cnt = 0;
    bit         e_req = 0, e_led = 0;
    logic [7:0] e_cnt = 8'd0;

    always @(posedge clk) begin
        bit s2pre, press_now;
        cyc++;
        if (rst) begin
            d1 = 0; d2 = 0; m_st = 0; armed = 0; dis_start = -1;
            mstate = 0; m_cnt = 0;
        end else begin
            s2pre = d2; d2 = d1; d1 = button;
            press_now = armed;
            armed = 0;
            if (s2pre != m_st) begin
                if (dis_start < 0) dis_start = cyc;
                if (cyc - dis_start + 1 == DT) begin
                    m_st = s2pre;
                    dis_start = -1;
                    armed = m_st;
                end
            end else begin
                dis_start = -1;
            end
            if (press_now && m_cnt < 255) m_cnt++;
            case (mstate)
                0: if (press_now) begin mstate = 1; since = cyc; end
                1: if (ack) begin mstate = 2; since = cyc; end
                default: if (cyc - since == LT) mstate = 0;
            endcase
        end
        e_req = (mstate == 1);
        e_led = (mstate == 1) && (((cyc - since) / BT) % 2 == 0);
        e_cnt = 8'(m_cnt);
    end

    task automatic step(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset();
        button = 0; ack = 0; rst = 1;
        step(2);
        rst = 0;
        for (int i = 0; i < 20; i++) begin
            step(1);
            vectors++;
            if ({ped_req, led, press_count} !== 10'd0) begin
                miscompares++;
                $display("FAIL reset @%0d: req=%b led=%b cnt=%0d, want all 0", cyc, ped_req, led, press_count);
            end
        end
    endtask

    task automatic test_clean_press();
        int k;
        bit pat[7] = '{1, 1, 1, 0, 0, 0, 1};
        button = 1;
        k = cyc + 1;
        for (int i = 0; i < 14; i++) begin
            step(1);
            if (cyc == k + DT + 1) begin
                vectors++;
                if (ped_req !== 1'b0) begin
                    miscompares++;
                    $display("FAIL clean_early @%0d: req=%b, want 0", cyc, ped_req);
                end
            end
            if (cyc >= k + DT + 2 && cyc <= k + DT + 8) begin
                vectors++;
                if (ped_req !== 1'b1 || led !== pat[cyc - k - DT - 2]) begin
                    miscompares++;
                    $display("FAIL clean_blink @%0d: req=%b led=%b, want 1 %b", cyc, ped_req, led, pat[cyc - k - DT - 2]);
                end
            end
        end
        vectors++;
        if (press_count !== 8'd1) begin
            miscompares++;
            $display("FAIL clean_count: cnt=%0d, want 1", press_count);
        end
    endtask

    task automatic test_ack_lockout();
        int m;
        logic [7:0] c0;
        button = 0;
        step(DT + 4);
        c0 = press_count;
        button = 1;
        step(3);
        ack = 1;
        step(1);
        m = cyc;
        ack = 0;
        vectors++;
        if (ped_req !== 1'b0 || led !== 1'b0) begin
            miscompares++;
            $display("FAIL ack_edge @%0d: req=%b led=%b, want 0 0", cyc, ped_req, led);
        end
        while (cyc < m + LT) begin
            step(1);
            vectors++;
            if (ped_req !== 1'b0) begin
                miscompares++;
                $display("FAIL lockout_req @%0d: req=%b, want 0", cyc, ped_req);
            end
        end
        vectors++;
        if (press_count !== c0 + 8'd1) begin
            miscompares++;
            $display("FAIL lockout_count: cnt=%0d, want %0d", press_count, c0 + 8'd1);
        end
        button = 0;
        step(DT + 4);
        button = 1;
        step(DT + 3);
        vectors++;
        if (ped_req !== 1'b1 || press_count !== c0 + 8'd2) begin
            miscompares++;
            $display("FAIL after_lockout: req=%b cnt=%0d, want 1 %0d", ped_req, press_count, c0 + 8'd2);
        end
        ack = 1; step(1); ack = 0;
        step(LT + 1);
        button = 0;
        step(DT + 4);
    endtask

    task automatic test_edge_cases();
        int en, m;
        logic [7:0] c0;
        c0 = press_count;
        ack = 1; step(3); ack = 0; step(1);
        vectors++;
        if (ped_req !== 1'b0 || led !== 1'b0 || press_count !== c0) begin
            miscompares++;
            $display("FAIL idle_ack: req=%b led=%b cnt=%0d, want 0 0 %0d", ped_req, led, press_count, c0);
        end
        // press event and ack land on the same IDLE edge
        button = 1;
        step(DT + 2);
        ack = 1;
        step(1);
        ack = 0;
        en = cyc;
        vectors++;
        if (ped_req !== 1'b1 || led !== 1'b1) begin
            miscompares++;
            $display("FAIL press_ack_same @%0d: req=%b led=%b, want 1 1", cyc, ped_req, led);
        end
        button = 0;
        step(DT + 4);
        button = 1;
        step(DT + 3);
        for (int i = 0; i < 8; i++) begin
            step(1);
            vectors++;
            if (ped_req !== 1'b1 || led !== (((cyc - en) / BT) % 2 == 0)) begin
                miscompares++;
                $display("FAIL second_press @%0d: req=%b led=%b, want 1 %b", cyc, ped_req, led, ((cyc - en) / BT) % 2 == 0);
            end
        end
        vectors++;
        if (press_count !== c0 + 8'd2) begin
            miscompares++;
            $display("FAIL second_press_count: cnt=%0d, want %0d", press_count, c0 + 8'd2);
        end
        ack = 1; step(1); ack = 0;
        step(LT + 1);
        button = 0;
        step(DT + 4);
        // press event coinciding with the LOCKOUT->IDLE edge is dropped
        button = 1;
        step(DT + 3);
        button = 0;
        step(DT + 4);
        c0 = press_count;
        button = 1;
        step(DT + 2 - LT);
        ack = 1;
        step(1);
        ack = 0;
        m = cyc;
        while (cyc < m + LT + 3) begin
            step(1);
            vectors++;
            if (ped_req !== 1'b0) begin
                miscompares++;
                $display("FAIL lockout_boundary @%0d: req=%b, want 0", cyc, ped_req);
            end
        end
        vectors++;
        if (press_count !== c0 + 8'd1) begin
            miscompares++;
            $display("FAIL boundary_count: cnt=%0d, want %0d", press_count, c0 + 8'd1);
        end
        button = 0;
        step(DT + 4);
        for (int i = 0; i < 300; i++) begin
            button = 1; step(DT + 3);
            button = 0; step(DT + 3);
        end
        vectors++;
        if (press_count !== 8'd255) begin
            miscompares++;
            $display("FAIL saturate: cnt=%0d, want 255", press_count);
        end
        ack = 1; step(1); ack = 0;
        step(LT + 2);
    endtask

    task automatic test_reset_mid_request();
        int r;
        button = 1;
        step(DT + 3);
        vectors++;
        if (ped_req !== 1'b1) begin
            miscompares++;
            $display("FAIL mid_setup: req=%b, want 1", ped_req);
        end
        rst = 1;
        step(1);
        r = cyc;
        rst = 0;
        vectors++;
        if ({ped_req, led, press_count} !== 10'd0) begin
            miscompares++;
            $display("FAIL mid_reset @%0d: req=%b led=%b cnt=%0d, want all 0", cyc, ped_req, led, press_count);
        end
        // synchronizer restarts at r, so the held button is first sampled at r+1
        while (cyc < r + DT + 3) begin
            step(1);
            vectors++;
            if (ped_req !== (cyc == r + DT + 3)) begin
                miscompares++;
                $display("FAIL mid_relatch @%0d: req=%b, want %b", cyc, ped_req, cyc == r + DT + 3);
            end
        end
        ack = 1; step(1); ack = 0;
        step(LT + 1);
        button = 0;
        step(DT + 4);
    endtask

    task automatic test_random();
        int len;
        for (int i = 0; i < 300; i++) begin
            button = 1'($urandom_range(0, 1));
            len = $urandom_range(1, 12);
            for (int j = 0; j < len; j++) begin
                ack = ($urandom_range(0, 7) == 0);
                rst = ($urandom_range(0, 199) == 0);
                step(1);
                vectors++;
                if ({ped_req, led, press_count} !== {e_req, e_led, e_cnt}) begin
                    miscompares++;
                    $display("FAIL random @%0d: req=%b led=%b cnt=%0d, want %b %b %0d",
                             cyc, ped_req, led, press_count, e_req, e_led, e_cnt);
                end
            end
        end
        rst = 0;
        ack = 0;
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_ack_lockout();
        test_edge_cases();
        test_reset_mid_request();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: run did not complete, %0d miscompares so far", miscompares);
        $fatal(1);
    end
endmodule
